spi_level_tx: RTL
=================

# spi_level_tx

SPI-mode-0 master transmitter that serialises 16-bit words from the system clock domain onto `cs_n`/`sclk`/`sdo`. It is the sending end of the PWM-level link: its outputs drive a remote receiver that shifts `sdi` on rising `sclk` while `cs_n` is low and latches the word on the rising edge of `cs_n`. Upstream logic presents a word with a valid/ready handshake. The block generates all SPI timing from `clk` and guarantees a `cs_n` high gap long enough for the receiver's 3-stage `cs_n` synchroniser.

## Interface
- `DATA_W`, 16, frame length in bits; fixed to match the receiver.
- `CLK_DIV`, 4, `clk` cycles per `sclk` half-period; legal range ≥2 (elaboration error otherwise).
- `CS_GAP`, 4, `clk` cycles `cs_n` stays high after a frame before the next may start; legal range ≥4.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `tx_data`  in  DATA_W  word to send, MSB first.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  block can accept a word.
- `cs_n`  out  1  SPI chip select, active low; registered.
- `sclk`  out  1  SPI clock, idle low; registered.
- `sdo`  out  1  SPI data to the receiver's `sdi`; registered.
- `busy`  out  1  high from accept through end of gap.
- `done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
- Reset values: `cs_n`=1, `sclk`=0, `sdo`=0, `busy`=0, `done`=0, state IDLE, `tx_ready`=1.
- `tx_ready` = (state==IDLE). Accept when `tx_valid && tx_ready`: capture `tx_data` into the shift register and go to SETUP.
- SETUP: `cs_n`=0, `sclk`=0, `sdo`=bit 15.
- SHIFT_HI: `sclk`=1; the receiver samples here.
- SHIFT_LO: `sclk`=0; `sdo` advances to the next bit on entry.
- Bit sequencing: after the 16th SHIFT_HI, go to HOLD (`sclk`=0, `sdo` held).
- After HOLD: `cs_n`=1, `done` pulses, then GAP.
- After GAP: return to IDLE.
- Every phase (SETUP/HI/LO/HOLD) lasts exactly CLK_DIV cycles. GAP lasts CS_GAP cycles.
- Bit counter is 5 bits and counts 0..15; no wrap beyond 15.
- `tx_data`/`tx_valid` are ignored while not IDLE.
- Reset mid-frame: outputs return asynchronously to reset values and no `done` pulse is issued. The receiver will latch a partial word on the resulting `cs_n` rise; upstream must resend after reset.

## Timing
- Accept at edge N → `cs_n`=0 and `sdo`=bit 15 from N+1.
- First `sclk` rise at N+1+CLK_DIV.
- `cs_n` low for 33·CLK_DIV cycles: 1 setup + 16 high + 15 low + 1 hold phase.
- `done` is high the same cycle `cs_n` first returns high.
- `tx_ready` rises CS_GAP cycles after `cs_n` rises.
- Back-to-back throughput: one word per 33·CLK_DIV + CS_GAP + 1 cycles.
- `sdo` changes only while `sclk` is low, giving ≥CLK_DIV cycles setup and hold around each rising edge.

## Configuration
- `SPI_TX_DEDUP_EN`
  - Defined: keep a `last_sent` register (reset 16'h0000). An accepted word equal to `last_sent` is consumed with no frame: `cs_n` stays high, no `done`, `tx_ready` high again next cycle. `last_sent` updates only when a frame completes with `done`.
  - Undefined: every accepted word is transmitted.

## Structure
- Package `spi_pkg`: `SPI_DATA_W` constant (16), state enum `spi_tx_state_t`, minimum constants for `CLK_DIV` and `CS_GAP`.
- Sub-module `spi_phase_tick`: down-counter reloaded with CLK_DIV-1 (or CS_GAP-1). Emits a one-cycle `tick` at phase end; restarts on `load`.

## Test plan
- CLK_DIV=2, CS_GAP=4, send 16'hA5C3 → bits sampled on `sclk` rises are 1010_0101_1100_0011; `cs_n` low 66 cycles; one `done`; `tx_ready` returns 4 cycles after `cs_n` rises.
- `tx_valid` held high with 16'h0001 then 16'hFFFF → two frames; `cs_n` high exactly CS_GAP+1 cycles between them; no `sdo` change while `sclk`=1.
- Loopback into a behavioural receiver model (3-flop `cs_n` sync on a 37 MHz clock) with 16'h8000 → model `level`=16'h8000.
- `rst_n` low during bit 7 of 16'h1234 → `cs_n`=1, `sclk`=0, `sdo`=0 immediately; no `done`; next word 16'h00FF sent intact.
- With `SPI_TX_DEDUP_EN`, send 16'h0042 twice → one frame, one `done`; second handshake completes in one cycle.
- `tx_valid` toggling mid-frame with differing `tx_data` → transmitted word unchanged; accepted only in IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI level-link transmitter.
package spi_pkg;

  localparam int SPI_DATA_W      = 16;
  localparam int SPI_BIT_CNT_W   = 5;
  localparam int SPI_MIN_CLK_DIV = 2;
  localparam int SPI_MIN_CS_GAP  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_HOLD,
    ST_GAP
  } spi_tx_state_t;

  function automatic int spi_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_phase_tick.sv
// Phase timer: reloadable down-counter that emits a single-cycle tick when the
// loaded count has fully elapsed; it stays quiet until loaded again.
module spi_phase_tick
  import spi_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  assign o_tick = r_run && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_run <= 1'b1;
    end else if (o_tick) begin
      r_run <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_level_tx.sv
// SPI mode-0 master transmitter for the PWM-level link (MSB first, cs_n gap after each frame).
// Optional build macro SPI_TX_DEDUP_EN: drop words equal to the last word actually sent.
module spi_level_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              cs_n,
  output logic              sclk,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(spi_max(CLK_DIV, CS_GAP));
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(CS_GAP - 1);
  localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(DATA_W - 1);

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_clk_div
    $error("spi_level_tx: CLK_DIV must be >= %0d", SPI_MIN_CLK_DIV);
  end
  if (CS_GAP < SPI_MIN_CS_GAP) begin : g_bad_cs_gap
    $error("spi_level_tx: CS_GAP must be >= %0d", SPI_MIN_CS_GAP);
  end
  if (DATA_W != SPI_DATA_W) begin : g_bad_data_w
    $error("spi_level_tx: DATA_W must be %0d", SPI_DATA_W);
  end

  spi_tx_state_t            r_state, w_state_next;
  logic [DATA_W-1:0]        r_shift, w_shift_next;
  logic [SPI_BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
  logic                     r_cs_n, w_cs_n_next;
  logic                     r_sclk, w_sclk_next;
  logic                     r_sdo, w_sdo_next;
  logic                     r_done, w_done_next;
  logic                     w_load;
  logic [CNT_W-1:0]         w_load_val;
  logic                     w_tick;
  logic                     w_dup;
  logic                     w_accept;

  spi_phase_tick #(.CNT_W(CNT_W)) u_phase_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tick     (w_tick)
  );

  assign tx_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign cs_n     = r_cs_n;
  assign sclk     = r_sclk;
  assign sdo      = r_sdo;
  assign done     = r_done;
  assign w_accept = tx_valid && tx_ready;

`ifdef SPI_TX_DEDUP_EN
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_last_sent;

  assign w_dup = (tx_data == r_last_sent);

  // last_sent follows only frames that really reached the receiver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word      <= '0;
      r_last_sent <= '0;
    end else begin
      if (w_accept && !w_dup) begin
        r_word <= tx_data;
      end
      if (r_state == ST_HOLD && w_tick) begin
        r_last_sent <= r_word;
      end
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_cs_n_next    = r_cs_n;
    w_sclk_next    = r_sclk;
    w_sdo_next     = r_sdo;
    w_done_next    = 1'b0;
    w_load         = 1'b0;
    w_load_val     = DIV_RELOAD;

    case (r_state)
      ST_IDLE: begin
        // r_shift keeps the not-yet-driven bits left-aligned; the MSB goes out now
        if (w_accept && !w_dup) begin
          w_state_next   = ST_SETUP;
          w_shift_next   = {tx_data[DATA_W-2:0], 1'b0};
          w_bit_cnt_next = '0;
          w_cs_n_next    = 1'b0;
          w_sclk_next    = 1'b0;
          w_sdo_next     = tx_data[DATA_W-1];
          w_load         = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_state_next = ST_SHIFT_HI;
          w_sclk_next  = 1'b1;
          w_load       = 1'b1;
        end
      end
      ST_SHIFT_HI: begin
        if (w_tick) begin
          w_sclk_next = 1'b0;
          w_load      = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = ST_HOLD;
          end else begin
            w_state_next   = ST_SHIFT_LO;
            w_sdo_next     = r_shift[DATA_W-1];
            w_shift_next   = {r_shift[DATA_W-2:0], 1'b0};
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_SHIFT_LO: begin
        if (w_tick) begin
          w_state_next = ST_SHIFT_HI;
          w_sclk_next  = 1'b1;
          w_load       = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_state_next = ST_GAP;
          w_cs_n_next  = 1'b1;
          w_sdo_next   = 1'b0;
          w_done_next  = 1'b1;
          w_load       = 1'b1;
          w_load_val   = GAP_RELOAD;
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cs_n_next  = 1'b1;
        w_sclk_next  = 1'b0;
        w_sdo_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_sdo     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_cs_n    <= w_cs_n_next;
      r_sclk    <= w_sclk_next;
      r_sdo     <= w_sdo_next;
      r_done    <= w_done_next;
    end
  end

endmodule
